// File: rtl/fft_pkg.sv
// Shared FFT types and the quarter-wave cosine table generator.
package fft_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ONE_CODE   = 1 << (DATA_WIDTH - 2);

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] data_r;
      logic signed [DATA_WIDTH-1:0] data_i;
   } FFT_DATA_SAMPLE;

   // Entry idx of cos(pi/2 * idx / (N/4)) in Q1.(DATA_WIDTH-2), clamped so +1.0 never overflows.
   function automatic logic signed [DATA_WIDTH-1:0] cos_entry(input int idx, input int set);
      real pi;
      real v;
      int  q;
      int  code;
      pi   = 3.14159265358979323846;
      q    = 1 << (set - 2);
      v    = $cos(pi / 2.0 * real'(idx) / real'(q)) * real'(ONE_CODE);
      code = $rtoi(v + 0.5);
      if (code > ONE_CODE) code = ONE_CODE;
      if (code < 0) code = 0;
      return DATA_WIDTH'(code);
   endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: quarter-wave cosine table plus symmetry mapping.
module fft_twiddle_rom
   import fft_pkg::*;
#(
   parameter int SET = 3
) (
   input  logic [SET-2:0]  k,
   output FFT_DATA_SAMPLE  twiddle
);

   localparam int REAL_SET = SET - 1;
   localparam int QN       = 1 << (SET - 2);
   localparam logic [REAL_SET:0] Q    = (REAL_SET + 1)'(QN);
   localparam logic [REAL_SET:0] HALF = (REAL_SET + 1)'(1 << REAL_SET);

   logic signed [DATA_WIDTH-1:0] cos_tab [0:QN];

   for (genvar g = 0; g <= QN; g++) begin : g_tab
      localparam logic signed [DATA_WIDTH-1:0] C_G = cos_entry(g, SET);
      assign cos_tab[g] = C_G;
   end

   logic [REAL_SET:0]   kk;
   logic [REAL_SET-1:0] idx_r;
   logic [REAL_SET-1:0] idx_i;
   logic                neg_r;

   // First quadrant reads C directly; second quadrant mirrors around N/4 and flips the real sign.
   always_comb begin
      kk    = {1'b0, k};
      idx_r = '0;
      idx_i = '0;
      neg_r = 1'b0;
      if (kk <= Q) begin
         idx_r = REAL_SET'(kk);
         idx_i = REAL_SET'(Q - kk);
      end else begin
         idx_r = REAL_SET'(HALF - kk);
         idx_i = REAL_SET'(kk - Q);
         neg_r = 1'b1;
      end
   end

   always_comb begin
      twiddle.data_r = neg_r ? -cos_tab[idx_r] : cos_tab[idx_r];
      twiddle.data_i = -cos_tab[idx_i];
   end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Twiddle sequence generator: one W_N^k per accepted valid, stride 2^stage.
// Optional conjugate output for inverse FFT via FFT_TWIDDLE_INVERSE_EN.
module fft_twiddle_gen
   import fft_pkg::*;
#(
   parameter int SET     = 3,
   parameter int STAGE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic [STAGE_W-1:0] stage,
`ifdef FFT_TWIDDLE_INVERSE_EN
   input  logic               inverse,
`endif
   input  logic               valid,
   output FFT_DATA_SAMPLE     out,
   output logic               out_valid
);

   localparam int REAL_SET = SET - 1;

   logic [REAL_SET-1:0] k;
   logic [REAL_SET-1:0] stride;
   logic [REAL_SET-1:0] stride_next;
   FFT_DATA_SAMPLE      rom_out;
   FFT_DATA_SAMPLE      tw;
   int                  lim;

   fft_twiddle_rom #(.SET(SET)) u_rom (
      .k       (k),
      .twiddle (rom_out)
   );

   // Stride saturates at N/4 so large stage numbers still walk a legal index.
   always_comb begin
      lim         = (int'(stage) > REAL_SET - 1) ? REAL_SET - 1 : int'(stage);
      stride_next = '0;
      for (int i = 0; i < REAL_SET; i++) begin
         if (i == lim) stride_next[i] = 1'b1;
      end
   end

`ifdef FFT_TWIDDLE_INVERSE_EN
   logic inv_q;

   always_comb begin
      tw = rom_out;
      if (inv_q) tw.data_i = -rom_out.data_i;
   end
`else
   assign tw = rom_out;
`endif

   // Valid/ready: no backpressure; each valid high on a rising edge (without clear) yields
   // one twiddle registered with out_valid=1 at that edge; clear wins over valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= '0;
         stride    <= REAL_SET'(1);
         out_valid <= 1'b0;
         out       <= '0;
`ifdef FFT_TWIDDLE_INVERSE_EN
         inv_q     <= 1'b0;
`endif
      end else if (clear) begin
         k         <= '0;
         stride    <= stride_next;
         out_valid <= 1'b0;
`ifdef FFT_TWIDDLE_INVERSE_EN
         inv_q     <= inverse;
`endif
      end else if (valid) begin
         out       <= tw;
         out_valid <= 1'b1;
         k         <= k + stride;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed bench for fft_twiddle_gen at SET=3, DATA_WIDTH=16.
module tb_fft_twiddle_gen;
   import fft_pkg::*;

   localparam int P = 16384;
   localparam int H = 11585;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [3:0]  stage;
   logic        inverse;
   logic        valid;
   logic [31:0] out_w;
   logic        out_valid;

   int checks;
   int errors;
   logic [31:0] exp_q[$];

   fft_twiddle_gen #(.SET(3), .STAGE_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .stage     (stage),
`ifdef FFT_TWIDDLE_INVERSE_EN
      .inverse   (inverse),
`endif
      .valid     (valid),
      .out       (out_w),
      .out_valid (out_valid)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] tw(input int r, input int i);
      tw = {r[15:0], i[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver: hold inputs across one rising edge, sample 1ns after it
   task automatic step(input logic c, input logic v, input logic [3:0] s);
      clear = c;
      valid = v;
      stage = s;
      @(posedge clk);
      #1;
      clear = 1'b0;
      valid = 1'b0;
   endtask

   task automatic run_valids(input string tag, input int n);
      logic [31:0] e;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, stage);
         e = exp_q.pop_front();
         check(tag, out_w, e);
         check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      clear   = 1'b0;
      valid   = 1'b0;
      stage   = '0;
      inverse = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", out_w, 32'd0);
      check("rst_ov", {31'b0, out_valid}, 32'd0);
      #3 rst_n = 1'b1;

      // stage 0: full stride-1 walk with wrap
      step(1'b1, 1'b0, 4'd0);
      check("clr0_ov", {31'b0, out_valid}, 32'd0);
      exp_q.push_back(tw(P, 0));
      exp_q.push_back(tw(H, -H));
      exp_q.push_back(tw(0, -P));
      exp_q.push_back(tw(-H, -H));
      exp_q.push_back(tw(P, 0));
      run_valids("s0", 5);
      step(1'b0, 1'b0, 4'd0);
      check("idle_ov", {31'b0, out_valid}, 32'd0);
      check("idle_hold", out_w, tw(P, 0));

      // stage 1: stride 2
      step(1'b1, 1'b0, 4'd1);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(tw(P, 0));
         exp_q.push_back(tw(0, -P));
      end
      run_valids("s1", 4);

      // stage 7: stride saturates to 2
      step(1'b1, 1'b0, 4'd7);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(tw(P, 0));
         exp_q.push_back(tw(0, -P));
      end
      run_valids("s7", 4);

      // clear and valid together: valid dropped, out held
      step(1'b0, 1'b1, 4'd0);
      check("pre_cv", out_w, tw(P, 0));
      step(1'b1, 1'b1, 4'd0);
      check("cv_ov", {31'b0, out_valid}, 32'd0);
      check("cv_hold", out_w, tw(P, 0));
      exp_q.push_back(tw(P, 0));
      exp_q.push_back(tw(H, -H));
      run_valids("cv", 2);

      // async reset mid-sequence
      step(1'b1, 1'b0, 4'd0);
      exp_q.push_back(tw(P, 0));
      exp_q.push_back(tw(H, -H));
      run_valids("pre_rst", 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out", out_w, 32'd0);
      check("arst_ov", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(tw(P, 0));
      exp_q.push_back(tw(H, -H));
      run_valids("post_rst", 2);

`ifdef FFT_TWIDDLE_INVERSE_EN
      inverse = 1'b1;
      step(1'b1, 1'b0, 4'd0);
      inverse = 1'b0;
      exp_q.push_back(tw(P, 0));
      exp_q.push_back(tw(H, H));
      run_valids("inv", 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
